// File: rtl/psl_command_responder.sv
// PSL command responder: accepts one CAPI command at a time, moves a 128-byte
// line between the backing store and the AFU buffer, and returns a response.
module psl_command_responder #(
   parameter int unsigned RESPONSE_DELAY = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            command_valid,
   input  logic [7:0]      command_tag,
   input  logic [12:0]     command_code,
   input  logic            command_parity,
   input  logic [63:0]     command_address,
   input  logic [11:0]     command_size,
   output logic            buffer_write_valid,
   output logic [7:0]      buffer_write_tag,
   output logic [5:0]      buffer_write_address,
   output logic [511:0]    buffer_write_data,
   output logic            buffer_write_parity,
   output logic            buffer_read_valid,
   output logic [7:0]      buffer_read_tag,
   output logic [5:0]      buffer_read_address,
   input  logic [511:0]    buffer_read_data,
   input  logic [3:0]      buffer_read_latency,
   output logic            response_valid,
   output logic [7:0]      response_tag,
   output logic [7:0]      response_code,
   output logic [8:0]      response_credits,
   output logic            mem_valid,
   output logic            mem_write,
   output logic [63:0]     mem_address,
   output logic [1023:0]   mem_write_data,
   input  logic            mem_ready,
   input  logic [1023:0]   mem_read_data
);

   localparam logic [12:0] READ_CL_NA = 13'h0A00;
   localparam logic [12:0] WRITE_NA   = 13'h0D00;
   localparam logic [3:0]  DLY_INIT   = 4'(RESPONSE_DELAY - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_MEM_READ, S_BUF_WRITE0, S_BUF_WRITE1, S_BUF_READ0,
      S_BUF_READ1, S_READ_WAIT, S_MEM_WRITE, S_RESPOND
   } state_t;

   state_t          r_state, w_next;
   logic [7:0]      r_tag;
   logic [63:0]     r_addr;
   logic [3:0]      r_lat;
   logic [7:0]      r_rsp;
   logic [1023:0]   r_line;
   logic [4:0]      r_cyc;
   logic [3:0]      r_dly;

   logic            w_cmd_bad, w_addr_bad, w_half0_cyc, w_half1_cyc;

   assign w_cmd_bad   = (command_parity != ~^command_code) ||
                        ((command_code != READ_CL_NA) && (command_code != WRITE_NA));
   assign w_addr_bad  = (|command_address[6:0]) || (command_size != 12'd128);
   // r_cyc counts cycles since the first buffer read request (cycle N = 0)
   assign w_half0_cyc = (r_cyc == {1'b0, r_lat});
   assign w_half1_cyc = (r_cyc == ({1'b0, r_lat} + 5'd1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:
            if (command_valid) begin
               if (w_cmd_bad || w_addr_bad)        w_next = S_RESPOND;
               else if (command_code == READ_CL_NA) w_next = S_MEM_READ;
               else                                 w_next = S_BUF_READ0;
            end
         S_MEM_READ:   if (mem_ready) w_next = S_BUF_WRITE0;
         S_BUF_WRITE0: w_next = S_BUF_WRITE1;
         S_BUF_WRITE1: w_next = S_RESPOND;
         S_BUF_READ0:  w_next = S_BUF_READ1;
         S_BUF_READ1:  w_next = S_READ_WAIT;
         S_READ_WAIT:  if (w_half1_cyc) w_next = S_MEM_WRITE;
         S_MEM_WRITE:  if (mem_ready) w_next = S_RESPOND;
         S_RESPOND:    if (r_dly == '0) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tag  <= '0;
         r_addr <= '0;
         r_lat  <= '0;
         r_rsp  <= '0;
         r_line <= '0;
         r_cyc  <= '0;
         r_dly  <= '0;
      end else begin
         if (r_state == S_IDLE && command_valid) begin
            r_tag  <= command_tag;
            r_addr <= command_address;
            r_lat  <= buffer_read_latency;
            r_cyc  <= '0;
            r_rsp  <= w_cmd_bad ? 8'h05 : (w_addr_bad ? 8'h01 : 8'h00);
         end
         if (r_state == S_MEM_READ && mem_ready) r_line <= mem_read_data;
         if (r_state == S_BUF_READ0 || r_state == S_BUF_READ1 || r_state == S_READ_WAIT) begin
            r_cyc <= r_cyc + 5'd1;
            if (w_half0_cyc) r_line[1023:512] <= buffer_read_data;
            if (w_half1_cyc) r_line[511:0]    <= buffer_read_data;
         end
         // every path into RESPOND arms the same countdown
         if (w_next == S_RESPOND && r_state != S_RESPOND) r_dly <= DLY_INIT;
         else if (r_state == S_RESPOND && r_dly != '0)   r_dly <= r_dly - 4'd1;
      end
   end

   always_comb begin
      buffer_write_valid   = 1'b0;
      buffer_write_tag     = '0;
      buffer_write_address = '0;
      buffer_write_data    = '0;
      buffer_read_valid    = 1'b0;
      buffer_read_tag      = '0;
      buffer_read_address  = '0;
      response_valid       = 1'b0;
      response_tag         = '0;
      response_code        = '0;
      response_credits     = '0;
      mem_valid            = 1'b0;
      mem_write            = 1'b0;
      mem_address          = '0;
      mem_write_data       = '0;
      case (r_state)
         S_MEM_READ: begin
            mem_valid   = 1'b1;
            mem_address = r_addr;
         end
         S_BUF_WRITE0, S_BUF_WRITE1: begin
            buffer_write_valid   = 1'b1;
            buffer_write_tag     = r_tag;
            buffer_write_address = (r_state == S_BUF_WRITE1) ? 6'd1 : 6'd0;
            buffer_write_data    = (r_state == S_BUF_WRITE1) ? r_line[511:0] : r_line[1023:512];
         end
         S_BUF_READ0, S_BUF_READ1: begin
            buffer_read_valid   = 1'b1;
            buffer_read_tag     = r_tag;
            buffer_read_address = (r_state == S_BUF_READ1) ? 6'd1 : 6'd0;
         end
         S_MEM_WRITE: begin
            mem_valid      = 1'b1;
            mem_write      = 1'b1;
            mem_address    = r_addr;
            mem_write_data = r_line;
         end
         S_RESPOND:
            if (r_dly == '0) begin
               response_valid   = 1'b1;
               response_tag     = r_tag;
               response_code    = r_rsp;
               response_credits = 9'd1;
            end
         default: ;
      endcase
      buffer_write_parity = buffer_write_valid ? ~^buffer_write_data : 1'b0;
   end

endmodule
